// File: rtl/seq_signed_multiplier.sv
// Sequential radix-2 Booth multiplier for signed or unsigned N-bit operands.
// One add/subtract/skip step per RUN cycle; result is held on m until the next operation finishes.
module seq_signed_multiplier #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           is_signed,
   input  logic [N-1:0]   x,
   input  logic [N-1:0]   y,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] m
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       step;
   logic signed [N+1:0] mcand;
   logic signed [N+1:0] acc_a;
   logic signed [N+1:0] a_sum;
   logic [N:0]          acc_q;
   logic                q_m1;
   logic                accept;
   logic                last_step;
   logic [2*N+2:0]      shifted;

   assign accept    = start && ((state == IDLE) || (state == DONE));
   assign last_step = (step == CW'(N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_step) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Booth pair {q0, q-1}: 01 adds the multiplicand, 10 subtracts it, 00/11 skip.
   always_comb begin
      a_sum = acc_a;
      case ({acc_q[0], q_m1})
         2'b01:   a_sum = acc_a + mcand;
         2'b10:   a_sum = acc_a - mcand;
         default: a_sum = acc_a;
      endcase
   end

   // Arithmetic right shift of {A, Q}; the sign bit of A is replicated.
   assign shifted = {a_sum[N+1], a_sum, acc_q[N:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         acc_a <= '0;
         acc_q <= '0;
         q_m1  <= 1'b0;
         step  <= '0;
         m     <= '0;
      end else if (accept) begin
         mcand <= is_signed ? {{2{x[N-1]}}, x} : {2'b00, x};
         acc_a <= '0;
         acc_q <= {is_signed & y[N-1], y};
         q_m1  <= 1'b0;
         step  <= '0;
      end else if (state == RUN) begin
         acc_a <= shifted[2*N+2:N+1];
         acc_q <= shifted[N:0];
         q_m1  <= acc_q[0];
         step  <= step + 1'b1;
         if (last_step) m <= shifted[2*N-1:0];
      end
   end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Bench for seq_signed_multiplier: an N=5 instance for exhaustive checks and an N=8 instance
// for directed, random, mid-run, back-to-back and asynchronous-reset scenarios.
module tb_seq_signed_multiplier;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic        st5 = 1'b0, sg5 = 1'b0, busy5, done5;
   logic [4:0]  x5 = '0, y5 = '0;
   logic [9:0]  m5;

   logic        st8 = 1'b0, sg8 = 1'b0, busy8, done8;
   logic [7:0]  x8 = '0, y8 = '0;
   logic [15:0] m8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_signed_multiplier #(.N(5)) u5 (
      .clk(clk), .rst_n(rst_n), .start(st5), .is_signed(sg5),
      .x(x5), .y(y5), .busy(busy5), .done(done5), .m(m5)
   );

   seq_signed_multiplier #(.N(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .is_signed(sg8),
      .x(x8), .y(y8), .busy(busy8), .done(done8), .m(m8)
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: interpret operands as integers, multiply, keep the low 2n bits.
   function automatic longint ref_prod(input longint a, input longint b, input int n, input bit s);
      longint av, bv, p;
      av = a;
      bv = b;
      if (s && a[n-1]) av = a - (longint'(1) << n);
      if (s && b[n-1]) bv = b - (longint'(1) << n);
      p = av * bv;
      return p & ((longint'(1) << (2 * n)) - 1);
   endfunction

   task automatic run5(input logic [4:0] a, input logic [4:0] b, input logic s,
                       output int lat, output logic [9:0] res);
      st5 = 1'b1; x5 = a; y5 = b; sg5 = s;
      @(posedge clk); #1;
      st5 = 1'b0; x5 = 5'($urandom); y5 = 5'($urandom); sg5 = ~s;
      lat = 1;
      while (done5 !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      res = m5;
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output int lat, output logic [15:0] res);
      st8 = 1'b1; x8 = a; y8 = b; sg8 = s;
      @(posedge clk); #1;
      st8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); sg8 = ~s;
      lat = 1;
      while (done8 !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      res = m8;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || m8 !== 16'h0) begin
         fails++;
         $display("FAIL reset_async8: busy=%b done=%b m=%h, need 0 0 0000", busy8, done8, m8);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++;
      if (busy5 !== 1'b0 || done5 !== 1'b0 || m5 !== 10'h0) begin
         fail_print5("reset_clk5");
      end
      tests++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || m8 !== 16'h0) begin
         fails++;
         $display("FAIL reset_clk8: busy=%b done=%b m=%h, need 0 0 0000", busy8, done8, m8);
      end
      rst_n = 1'b1;
   endtask

   task automatic fail_print5(input string name);
      fails++;
      $display("FAIL %s: busy=%b done=%b m=%h, need 0 0 000", name, busy5, done5, m5);
   endtask

   task automatic test_directed_n8();
      logic [7:0]  xa [5] = '{8'h80, 8'hFF, 8'h7F, 8'hFF, 8'h00};
      logic [7:0]  ya [5] = '{8'h80, 8'h01, 8'h80, 8'hFF, 8'hA5};
      logic        sa [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [15:0] ea [5] = '{16'h4000, 16'hFFFF, 16'hC080, 16'hFE01, 16'h0000};
      int lat;
      logic [15:0] res;
      for (int i = 0; i < 5; i++) begin
         run8(xa[i], ya[i], sa[i], lat, res);
         tests++;
         if (lat != 10) begin
            fails++;
            $display("FAIL directed_lat[%0d]: done after %0d edges, need 10", i, lat);
         end
         tests++;
         if (res !== ea[i]) begin
            fails++;
            $display("FAIL directed_m[%0d]: got %h, need %h", i, res, ea[i]);
         end
      end
   endtask

   task automatic test_exhaustive_n5();
      int lat;
      logic [9:0] res, exp;
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
               run5(5'(a), 5'(b), 1'(s), lat, res);
               exp = 10'(ref_prod(longint'(a), longint'(b), 5, 1'(s)));
               tests++;
               if (lat != 7) begin
                  fails++;
                  $display("FAIL exh_lat s=%0d x=%0d y=%0d: done after %0d edges, need 7", s, a, b, lat);
               end
               tests++;
               if (res !== exp) begin
                  fails++;
                  $display("FAIL exh_m s=%0d x=%0d y=%0d: got %h, need %h", s, a, b, res, exp);
               end
            end
         end
      end
   endtask

   task automatic test_random_n8();
      int lat;
      logic [7:0]  a, b;
      logic        s;
      logic [15:0] res, exp;
      for (int i = 0; i < 200; i++) begin
         a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
         run8(a, b, s, lat, res);
         exp = 16'(ref_prod(longint'(a), longint'(b), 8, s));
         tests++;
         if (lat != 10 || res !== exp) begin
            fails++;
            $display("FAIL random s=%0d x=%h y=%h: m=%h lat=%0d, need m=%h lat=10", s, a, b, res, lat, exp);
         end
      end
   endtask

   task automatic test_midrun_n8();
      logic [15:0] exp;
      exp = 16'(ref_prod(longint'(8'h3A), longint'(8'hC5), 8, 1'b1));
      st8 = 1'b1; x8 = 8'h3A; y8 = 8'hC5; sg8 = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 9; i++) begin
         tests++;
         if (busy8 !== 1'b1) begin
            fails++;
            $display("FAIL midrun_busy cycle %0d: busy=%b, need 1", i, busy8);
         end
         st8 = 1'b1; x8 = 8'($urandom); y8 = 8'($urandom); sg8 = 1'($urandom);
         @(posedge clk); #1;
      end
      st8 = 1'b0;
      tests++;
      if (done8 !== 1'b1 || m8 !== exp) begin
         fails++;
         $display("FAIL midrun_result: done=%b m=%h, need done=1 m=%h", done8, m8, exp);
      end
      @(posedge clk); #1;
      tests++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
         fails++;
         $display("FAIL midrun_norestart: busy=%b done=%b, need 0 0", busy8, done8);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] q[$];
      logic [15:0] exp;
      logic        exp_done;
      st8 = 1'b1; x8 = 8'($urandom); y8 = 8'($urandom); sg8 = 1'($urandom);
      q.push_back(16'(ref_prod(longint'(x8), longint'(y8), 8, sg8)));
      @(posedge clk); #1;
      for (int k = 2; k <= 50; k++) begin
         @(posedge clk); #1;
         exp_done = ((k % 10) == 0);
         tests++;
         if (done8 !== exp_done) begin
            fails++;
            $display("FAIL b2b_done edge %0d: done=%b, need %b", k, done8, exp_done);
         end
         if (exp_done) begin
            exp = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
            tests++;
            if (m8 !== exp) begin
               fails++;
               $display("FAIL b2b_m edge %0d: got %h, need %h", k, m8, exp);
            end
            if (k < 50) begin
               x8 = 8'($urandom); y8 = 8'($urandom); sg8 = 1'($urandom);
               q.push_back(16'(ref_prod(longint'(x8), longint'(y8), 8, sg8)));
            end
         end
      end
      st8 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      int lat;
      int spurious;
      logic [15:0] res, exp;
      run8(8'h5A, 8'h33, 1'b0, lat, res);
      tests++;
      if (res !== 16'h11EE) begin
         fails++;
         $display("FAIL arst_pre: got %h, need 11ee", res);
      end
      st8 = 1'b1; x8 = 8'h77; y8 = 8'h99; sg8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      #3 rst_n = 1'b0;
      #1;
      tests++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || m8 !== 16'h0) begin
         fails++;
         $display("FAIL arst_immediate: busy=%b done=%b m=%h, need 0 0 0000", busy8, done8, m8);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done8 !== 1'b0 || busy8 !== 1'b0) spurious++;
      end
      tests++;
      if (spurious != 0) begin
         fails++;
         $display("FAIL arst_no_done: %0d cycles with busy/done after abort, need 0", spurious);
      end
      run8(8'h9C, 8'h37, 1'b1, lat, res);
      exp = 16'(ref_prod(longint'(8'h9C), longint'(8'h37), 8, 1'b1));
      tests++;
      if (lat != 10 || res !== exp) begin
         fails++;
         $display("FAIL arst_recover: m=%h lat=%0d, need m=%h lat=10", res, lat, exp);
      end
   endtask

   initial begin
      test_reset();
      test_directed_n8();
      test_exhaustive_n5();
      test_random_n8();
      test_midrun_n8();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_signed_multiplier.md
SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

Parameters
REQ-001 The block SHALL have parameter N, default 8, giving operand width in bits; legal range is 2 to 32.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiplication using the current x, y and is_signed.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned operands.
REQ-006 The block SHALL have port x, input, N bits: multiplicand.
REQ-007 The block SHALL have port y, input, N bits: multiplier.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multiplication is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the cycle in which the result first appears on m.
REQ-010 The block SHALL have port m, output, 2N bits: product, signed when is_signed was 1 at acceptance.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 IDLE SHALL move to RUN on a rising edge where start=1; otherwise the FSM SHALL stay in IDLE.
REQ-013 On acceptance, x, y and is_signed SHALL be latched internally; later changes on these inputs SHALL NOT affect the running operation.
REQ-014 Operands SHALL be extended to N+1 bits: sign-extended when is_signed=1, zero-extended when is_signed=0.
REQ-015 The block SHALL perform radix-2 Booth recoding on the extended operands, with one add, subtract or skip step plus an arithmetic right shift per RUN cycle.
REQ-016 RUN SHALL last exactly N+1 cycles, counted by an internal step counter, and SHALL then move to DONE.
REQ-017 DONE SHALL last exactly one cycle and SHALL then move to IDLE.
REQ-018 If start=1 during the DONE cycle, the request SHALL be accepted and the FSM SHALL move directly to RUN, allowing back-to-back operation.
REQ-019 busy SHALL be 1 exactly when the state is RUN.
REQ-020 done SHALL be 1 exactly when the state is DONE.
REQ-021 Latency from the accepting edge to done=1 SHALL be N+2 rising edges.
REQ-022 m SHALL be loaded with the lower 2N bits of the product on the edge that enters DONE.
REQ-023 m SHALL hold its value until the next entry into DONE, including through IDLE and RUN.
REQ-024 start SHALL be ignored while in RUN; no queuing and no restart.
REQ-025 The 2N-bit result SHALL be exact for all operand pairs in both modes, including signed (-2^(N-1))*(-2^(N-1)) = 2^(2N-2) and unsigned (2^N-1)^2; no saturation and no overflow flag.
REQ-026 A zero operand SHALL still take the full N+1 RUN cycles; there is no early termination.
REQ-027 The internal accumulator SHALL be at least 2N+2 bits wide so that no intermediate step overflows.

Reset
REQ-028 While rst_n=0, regardless of clk, the state SHALL be IDLE and busy, done, m, the step counter and all latched operands SHALL be 0.
REQ-029 Asserting rst_n during RUN SHALL abort the operation; no done pulse and no update of m SHALL follow.
REQ-030 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-031 Bench SHALL check exhaustive N=5, both modes, all 1024 operand pairs each: m SHALL equal the reference product, and done SHALL occur exactly N+2=7 edges after acceptance.
REQ-032 Bench SHALL check N=8, is_signed=1: x=0x80, y=0x80 -> m=0x4000; x=0xFF, y=0x01 -> m=0xFFFF; x=0x7F, y=0x80 -> m=0xC080.
REQ-033 Bench SHALL check N=8, is_signed=0: x=0xFF, y=0xFF -> m=0xFE01; x=0x00, y=0xA5 -> m=0x0000 after the full 9 RUN cycles.
REQ-034 Bench SHALL check start pulsed again and x/y changed mid-RUN: no restart, busy stays 1 for 9 cycles, and the first result is unaffected.
REQ-035 Bench SHALL check start held high continuously: one result per 10 cycles, done pulsing once per operation and never for two consecutive cycles.
REQ-036 Bench SHALL check rst_n driven low asynchronously mid-RUN (between clock edges): busy, done and m go to 0 immediately, no done follows, and the next start completes correctly.
